// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bundle between a byte source and program_loader.
interface program_loader_if;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [7:0]  words_loaded_o;
  logic        cpu_reset_n_o;

  modport slave (
    input  start_i, byte_i, byte_valid_i,
    output byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
           busy_o, done_o, error_o, words_loaded_o, cpu_reset_n_o
  );

  modport master (
    output start_i, byte_i, byte_valid_i,
    input  byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
           busy_o, done_o, error_o, words_loaded_o, cpu_reset_n_o
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte stream to little-endian program-memory words; holds the CPU in reset while loading.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-256 data checksum byte.
//
// state   | meaning
// IDLE    | waiting for start_i, CPU released
// LEN     | take length byte N
// DATA    | assemble bytes of the current word
// WRITE   | one-cycle memory write strobe
// CHECK   | take trailing checksum byte (checksum build only)
// DONE    | frame loaded, CPU released
// ERROR   | frame aborted, CPU held in reset
module program_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

  localparam logic [7:0] DEPTH_B   = 8'(MEMORY_DEPTH);
  localparam logic [1:0] LAST_LANE = 2'(DATA_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , S_CHECK = 3'd6
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              idx_q, idx_d;
  logic [1:0]              lane_q, lane_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    cpu_rst_n_q, cpu_rst_n_d;
  logic                    mem_write_q, mem_write_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic [7:0]              words_q, words_d;
  logic                    accept;

  assign accept = bus.byte_valid_i && ready_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    word_d     = word_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    words_d    = words_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start_i) begin
          state_d = S_LEN;
          words_d = 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          if (bus.byte_i == 8'd0 || bus.byte_i > DEPTH_B) begin
            state_d = S_ERROR;
          end else begin
            len_d   = bus.byte_i;
            idx_d   = 8'd0;
            lane_d  = 2'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{lane_q, 3'b000} +: 8] = bus.byte_i;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.byte_i;
`endif
          if (lane_q == LAST_LANE) begin
            lane_d     = 2'd0;
            state_d    = S_WRITE;
            mem_data_d = word_d;
            mem_addr_d = BASE_ADDRESS + {22'd0, idx_q, 2'b00};
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 8'd1;
        words_d = words_q + 8'd1;
        if (idx_q + 8'd1 == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (bus.byte_i == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    ready_d     = (state_d == S_LEN) || (state_d == S_DATA);
    busy_d      = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ready_d     = ready_d || (state_d == S_CHECK);
    busy_d      = busy_d  || (state_d == S_CHECK);
`endif
    mem_write_d = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    cpu_rst_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      word_q      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      words_q     <= words_d;
    end
  end

  assign bus.byte_ready_o   = ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.error_o        = error_q;
  assign bus.cpu_reset_n_o  = cpu_rst_n_q;
  assign bus.mem_write_o    = mem_write_q;
  assign bus.mem_address_o  = mem_addr_q;
  assign bus.mem_data_o     = mem_data_q;
  assign bus.words_loaded_o = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames for program_loader, checked against a frame-level reference model.
module tb_program_loader;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          compared   = 0;
  int          mismatched = 0;
  int          strobes    = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  frame_q[$];

  always @(negedge clk) begin
    if (bus.mem_write_o === 1'b1) begin
      obs_q.push_back({bus.mem_address_o, bus.mem_data_o});
      strobes++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_ready_o), 0);
    check({tag, "_busy"},  32'(bus.busy_o), 0);
    check({tag, "_done"},  32'(bus.done_o), 0);
    check({tag, "_error"}, 32'(bus.error_o), 0);
    check({tag, "_cpurst"}, 32'(bus.cpu_reset_n_o), 0);
    check({tag, "_wr"},    32'(bus.mem_write_o), 0);
    check({tag, "_addr"},  bus.mem_address_o, 0);
    check({tag, "_data"},  bus.mem_data_o, 0);
    check({tag, "_words"}, 32'(bus.words_loaded_o), 0);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    while (bus.byte_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept_timeout", 32'(n >= 200), 0);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n >= 100), 0);
  endtask

  // Sends one frame (length n, data from frame_q) and checks writes and final status.
  task automatic run_frame(input logic [7:0] n, input int gap_min, input int gap_max,
                           input bit bad_sum, input int start_at);
    logic [7:0]  sum;
    logic [31:0] w;
    bit          len_ok;
    bit          ok;
    int          nw;
    len_ok = (n != 0) && (int'(n) <= DEPTH);
    exp_q.delete();
    sum = 8'd0;
    if (len_ok) begin
      for (int i = 0; i < int'(n); i++) begin
        w = 32'(frame_q[4*i]) + 32'(frame_q[4*i+1]) * 256 +
            32'(frame_q[4*i+2]) * 65536 + 32'(frame_q[4*i+3]) * 16777216;
        exp_q.push_back({BASE + 32'(4 * i), w});
        for (int k = 0; k < 4; k++) sum = sum + frame_q[4*i+k];
      end
    end
    ok = len_ok;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ok = len_ok && !bad_sum;
`endif
    obs_q.delete();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("start_clears_done",  32'(bus.done_o), 0);
    check("start_clears_error", 32'(bus.error_o), 0);
    check("start_busy",         32'(bus.busy_o), 1);
    send_byte(n, $urandom_range(gap_min, gap_max));
    if (len_ok) begin
      for (int i = 0; i < 4 * int'(n); i++) begin
        if (i == start_at) begin
          bus.start_i = 1'b1;
          @(negedge clk);
          bus.start_i = 1'b0;
        end
        send_byte(frame_q[i], $urandom_range(gap_min, gap_max));
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(bad_sum ? sum + 8'd1 : sum, 0);
`endif
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("nwrites", 32'(obs_q.size()), 32'(exp_q.size()));
    nw = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nw; i++) begin
      check("wr_addr", obs_q[i][63:32], exp_q[i][63:32]);
      check("wr_data", obs_q[i][31:0],  exp_q[i][31:0]);
    end
    check("done",   32'(bus.done_o), 32'(ok));
    check("error",  32'(bus.error_o), 32'(!ok));
    check("cpurst", 32'(bus.cpu_reset_n_o), 32'(ok));
    check("busy",   32'(bus.busy_o), 0);
    check("ready",  32'(bus.byte_ready_o), 0);
    check("words",  32'(bus.words_loaded_o), len_ok ? 32'(n) : 0);
  endtask

  task automatic load_nominal();
    frame_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  endtask

  initial begin
    int s;
    logic [7:0] rn;
    bus.start_i      = 1'b0;
    bus.byte_i       = 8'd0;
    bus.byte_valid_i = 1'b0;

    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_cpurst", 32'(bus.cpu_reset_n_o), 1);
    check("idle_busy",   32'(bus.busy_o), 0);
    check("idle_ready",  32'(bus.byte_ready_o), 0);

    // Nominal load with literal expectations alongside the model.
    load_nominal();
    run_frame(8'd2, 0, 0, 1'b0, -1);
    check("nominal_w0_data", (obs_q.size() > 0) ? obs_q[0][31:0]  : 32'hx, 32'h1234_5678);
    check("nominal_w0_addr", (obs_q.size() > 0) ? obs_q[0][63:32] : 32'hx, 32'h0040_0000);
    check("nominal_w1_data", (obs_q.size() > 1) ? obs_q[1][31:0]  : 32'hx, 32'hDEAD_BEEF);
    check("nominal_w1_addr", (obs_q.size() > 1) ? obs_q[1][63:32] : 32'hx, 32'h0040_0004);
    check("nominal_hold_addr", bus.mem_address_o, 32'h0040_0004);

    // Bad lengths, then a valid frame clears the error.
    s = strobes;
    frame_q.delete();
    run_frame(8'h00, 0, 0, 1'b0, -1);
    run_frame(8'h21, 0, 0, 1'b0, -1);
    check("badlen_no_strobe", 32'(strobes), 32'(s));
    load_nominal();
    run_frame(8'd2, 0, 0, 1'b0, -1);

    // Flow control: three idle cycles before every byte.
    run_frame(8'd2, 3, 3, 1'b0, -1);

    // start_i during DATA is ignored.
    run_frame(8'd2, 0, 1, 1'b0, 2);

    // Reset mid-frame after two data bytes.
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    send_byte(8'd2, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    s = strobes;
    reset = 1'b0;
    #1 check_all_zero("midreset");
    repeat (6) @(negedge clk);
    check("midreset_no_strobe", 32'(strobes), 32'(s));
    reset = 1'b1;
    @(negedge clk);
    load_nominal();
    run_frame(8'd2, 0, 0, 1'b0, -1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(8'd1, 0, 0, 1'b0, -1);
    run_frame(8'd1, 0, 0, 1'b1, -1);
`endif

    // Maximum depth: word i holds value i.
    frame_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      frame_q.push_back(8'(i));
      frame_q.push_back(8'd0);
      frame_q.push_back(8'd0);
      frame_q.push_back(8'd0);
    end
    run_frame(8'(DEPTH), 0, 0, 1'b0, -1);
    check("maxdepth_last_addr", (obs_q.size() > 0) ? obs_q[obs_q.size()-1][63:32] : 32'hx,
          32'h0040_007C);

    // Randomized frames, including out-of-range lengths.
    for (int f = 0; f < 10; f++) begin
      rn = 8'($urandom_range(0, DEPTH + 8));
      frame_q.delete();
      for (int i = 0; i < 4 * int'(rn); i++) frame_q.push_back(8'($urandom_range(0, 255)));
      run_frame(rn, 0, 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Serial-to-memory writer for the instruction ROM path: accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one-cycle write strobes into a writable program memory starting at BASE_ADDRESS.
- Holds the CPU in reset while loading and releases it only after a successful load.
- Sits between a UART/debug byte source and the program memory write port.

Parameters:
- MEMORY_DEPTH, 32, maximum words per frame; must be 1..255.
- DATA_WIDTH, 32, word width; fixed at 32 (four bytes per word).
- BASE_ADDRESS, 32'h0040_0000, byte address of the first word written.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  pulse that begins a new frame.
- byte_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_i is valid.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- mem_write_o  output  1  one-cycle program memory write strobe.
- mem_address_o  output  32  byte address of the write.
- mem_data_o  output  32  word to write.
- busy_o  output  1  frame in progress.
- done_o  output  1  last frame completed successfully (level).
- error_o  output  1  last frame aborted (level).
- words_loaded_o  output  8  words written in the current or last frame.
- cpu_reset_n_o  output  1  active-low CPU reset.

Behaviour:
- All outputs are registered. Reset (reset=0, asynchronous) drives every output to 0, sets the state to IDLE, and clears all counters and the assembly register.
- A byte is transferred on a rising edge where byte_valid_i=1 and byte_ready_o=1. No byte is consumed otherwise.
- States:
  - IDLE: ready=0, busy=0, cpu_reset_n_o=1 (first clk after reset release). start_i -> LEN, and clears done_o, error_o, words_loaded_o and the checksum.
  - LEN: ready=1, busy=1, cpu_reset_n_o=0. Accepted byte is N. N=0 or N>MEMORY_DEPTH -> ERROR; otherwise store N, clear word index and byte lane -> DATA.
  - DATA: ready=1. Byte k of a word goes to bits [8k+7:8k], k=0..3 (first byte is the LSB). The 4th accepted byte -> WRITE.
  - WRITE: ready=0. mem_write_o=1 for exactly this cycle. mem_address_o=BASE_ADDRESS+4*index and mem_data_o=assembled word. mem_address_o and mem_data_o hold their values after the strobe. index and words_loaded_o increment. If index+1==N -> DONE (or CHECK when the feature is enabled); else -> DATA.
  - DONE: done_o=1, busy=0, cpu_reset_n_o=1, ready=0.
  - ERROR: error_o=1, busy=0, cpu_reset_n_o=0 (CPU stays held), ready=0.
- Latency: mem_write_o asserts on the clock edge after the 4th byte of a word is accepted. Peak throughput is one word per 5 cycles.
- start_i is ignored while busy_o=1. start_i in DONE or ERROR restarts at LEN.
- A byte presented while ready=0 (e.g. during WRITE) is not consumed. The source holds it, and it is taken on the next DATA cycle.
- Reset asserted mid-frame aborts immediately, with no further write strobes. Words already written remain in memory.
- Address arithmetic is modulo 2^32.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit modulo-256 sum of all data bytes is accumulated; the length byte is excluded.
  - After the last WRITE the state goes to CHECK (ready=1). One trailing byte is accepted.
  - If the byte equals the sum -> DONE; otherwise -> ERROR.
  - Words are already written before the check; on mismatch the CPU stays in reset.
- Undefined: no CHECK state, no trailing byte; the last WRITE goes directly to DONE.

Test Plan:
- Nominal load: reset, start, bytes 02, 78 56 34 12, EF BE AD DE -> two strobes: 0x12345678 @0x00400000 and 0xDEADBEEF @0x00400004. Then done_o=1, words_loaded_o=2, cpu_reset_n_o=1, error_o=0.
- Bad length: frame with N=0x00, then a frame with N=0x21 (MEMORY_DEPTH=32) -> error_o=1 each time, no mem_write_o, cpu_reset_n_o=0. A following valid start clears error_o.
- Flow control: same stream as the nominal load, with byte_valid_i low for 3 cycles between bytes and a byte held valid during WRITE -> identical writes, and each byte is consumed exactly once.
- Start while busy and reset mid-frame: start_i pulsed during DATA -> ignored. Reset dropped after 2 of 4 bytes -> all outputs 0, no strobe. After release, a fresh nominal frame succeeds.
- Checksum (macro defined): N=01, bytes 01 02 03 04, checksum 0A -> write 0x04030201, done_o=1. Repeat with checksum 0B -> write still occurs, error_o=1, cpu_reset_n_o=0.
- Max depth: N=32 with words 0..31 -> the last write is @0x0040007C, words_loaded_o=32, done_o=1.
